l2_cacheline_adaptor: RTL and testbench
=======================================

// Module: l2_cacheline_adaptor
// PURPOSE
//   Sits directly downstream of the L2 cache controller/datapath and upstream of physical memory.
//   Converts one 256-bit cacheline read or write request into a 4-beat, 64-bit burst transaction.
//   Returns a single-cycle resp_o when the whole line has transferred.
//   Reassembles read bursts into line_o; serialises line_i into burst_o for writes.
// PARAMETERS
//   LINE_WIDTH   256  cacheline width in bits (L2 side)
//   BURST_WIDTH  64   memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (=4)
//   ADDR_WIDTH   32   byte address width; line offset = log2(LINE_WIDTH/8) (=5) bits
// PORTS
//   clk        in   1            single clock; all state updates on posedge
//   rst        in   1            asynchronous, active-low reset (0 = reset)
//   read_i     in   1            L2 line read request, level, held until resp_o
//   write_i    in   1            L2 line write request, level, held until resp_o
//   address_i  in   ADDR_WIDTH   L2 line address (offset bits ignored)
//   line_i     in   LINE_WIDTH   line to write, valid while write_i high
//   line_o     out  LINE_WIDTH   assembled read line, valid in the cycle resp_o=1
//   resp_o     out  1            one-cycle completion pulse to L2
//   read_o     out  1            memory burst read request
//   write_o    out  1            memory burst write request
//   address_o  out  ADDR_WIDTH   latched line address, offset bits forced to 0
//   burst_o    out  BURST_WIDTH  current write beat (beat 0 = line bits [63:0])
//   burst_i    in   BURST_WIDTH  read beat from memory, valid when resp_i=1
//   resp_i     in   1            memory beat handshake, one per beat
// BEHAVIOUR
//   Reset (async, rst=0):
//     state=IDLE, beat counter=0; resp_o, read_o, write_o = 0.
//     address_o, burst_o, line_o buffer = 0.
//     Reset mid-burst aborts at once; no resp_o is issued.
//   States: IDLE, READ, WRITE, DONE.
//   IDLE:
//     write_i=1 -> WRITE; else read_i=1 -> READ. Write has priority if both are high.
//     On leaving IDLE: latch {address_i[31:5],5'b0} to address_o, latch line_i to the buffer,
//     and clear the beat counter.
//   READ:
//     read_o=1. Each cycle with resp_i=1, buffer[cnt*64 +: 64] <= burst_i and cnt++.
//     After the beat with cnt==BEATS-1 -> DONE.
//   WRITE:
//     write_o=1, burst_o = buffer[cnt*64 +: 64] (combinational from the counter).
//     Each cycle with resp_i=1, cnt++. After the last beat -> DONE.
//   resp_i=0 cycles in READ/WRITE are wait states; counter and outputs hold.
//   DONE:
//     resp_o=1 for exactly one cycle; read_o=write_o=0; line_o = buffer. Next state: IDLE.
//   Latency: first request cycle to resp_o = 1 (IDLE) + beat cycles incl. waits + 1 (DONE).
//     Minimum is 6 cycles.
//   After resp_o, IDLE samples the next request. This allows a write-back followed by a
//     refill read with one idle cycle between them.
//   Requests dropping mid-burst: the burst still completes and resp_o still pulses;
//     the L2 must ignore it.
//   address_i/line_i changes after the IDLE latch are ignored until the next IDLE.
//   Counter width is log2(BEATS); it wraps to 0 on the last beat.
//   resp_i in IDLE/DONE is ignored.
// TESTING
//   1) Read A=0x0000_1234: resp_i on 4 consecutive cycles with beats 0x11..,0x22..,0x33..,0x44..
//      -> address_o=0x0000_1220; read_o high for 5 cycles; resp_o pulses once;
//         line_o={0x44..,0x33..,0x22..,0x11..}.
//   2) Write line 0xDDDD..CCCC..BBBB..AAAA to 0x8000_0040 -> burst_o=0xAAAA.., then BB, CC, DD
//      on successive resp_i; write_o drops in DONE; resp_o pulses once.
//   3) Read with resp_i gaps (pattern 1,0,0,1,1,0,1)
//      -> beats land only on resp_i=1 cycles; resp_o pulses one cycle after the 4th beat.
//   4) read_i=write_i=1 in IDLE -> write burst is performed; read_o stays 0.
//   5) Write-back then refill (L2 write_back->pmem)
//      -> two transactions in order; one resp_o each; no overlap of read_o/write_o.
//   6) rst=0 asserted after 2 read beats
//      -> read_o=0 and resp_o=0 immediately; after release, a new read returns only new beats.

Source files
------------

// File: rtl/l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : l2_cacheline_adaptor
// Description : Bridges the L2 cache and physical memory. One cacheline read
//               or write from the L2 becomes a BEATS-long burst of
//               BURST_WIDTH-bit beats. Read beats are reassembled into
//               line_o. Write lines are serialised onto burst_o, with
//               beat 0 taken from the low bits of the line. A single-cycle
//               resp_o marks the end of each line transfer.
// Ports       :
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   read_i     L2 line read request, level, held until resp_o
//   write_i    L2 line write request, level, held until resp_o
//   address_i  L2 byte address; the line-offset bits are ignored
//   line_i     line to write, sampled when the request is accepted
//   line_o     assembled read line, valid while resp_o = 1
//   resp_o     one-cycle completion pulse to the L2
//   read_o     memory burst read request
//   write_o    memory burst write request
//   address_o  latched line address, with the offset bits forced to zero
//   burst_o    current write beat
//   burst_i    read beat from memory, valid while resp_i = 1
//   resp_i     memory beat handshake, one per beat
// Revision    : 1.0 - initial release
// ============================================================================
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int c_BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_OFFSET = $clog2(LINE_WIDTH / 8);

  localparam logic [c_CNT_W-1:0]    c_LAST_BEAT   = c_CNT_W'(c_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_OFFSET_MASK = ADDR_WIDTH'((64'd1 << c_OFFSET) - 64'd1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_last;

  assign w_last = (r_cnt == c_LAST_BEAT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A write wins when both requests are high, so that a
  // dirty victim is written back before its refill is read.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (write_i) begin
          w_next_state = c_WRITE;
        end else if (read_i) begin
          w_next_state = c_READ;
        end
      end
      c_READ: begin
        if (resp_i && w_last) begin
          w_next_state = c_DONE;
        end
      end
      c_WRITE: begin
        if (resp_i && w_last) begin
          w_next_state = c_DONE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. These are decoded from the state, so an asynchronous reset
  // drops the memory request and resp_o immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (r_state)
      c_READ: begin
        read_o = 1'b1;
      end
      c_WRITE: begin
        write_o = 1'b1;
        for (int i = 0; i < c_BEATS; i++) begin
          if (r_cnt == c_CNT_W'(i)) begin
            burst_o = r_buf[i*BURST_WIDTH +: BURST_WIDTH];
          end
        end
      end
      c_DONE: begin
        resp_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. The address and line are captured once, when leaving IDLE.
  // The L2 may change them afterwards without affecting the burst.
  // The beat counter wraps to zero naturally on the last beat.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (write_i || read_i) begin
            r_addr <= address_i & ~c_OFFSET_MASK;
            r_buf  <= line_i;
            r_cnt  <= '0;
          end
        end
        c_READ: begin
          if (resp_i) begin
            for (int i = 0; i < c_BEATS; i++) begin
              if (r_cnt == c_CNT_W'(i)) begin
                r_buf[i*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
              end
            end
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign address_o = r_addr;
  assign line_o    = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_l2_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_cacheline_adaptor
// Description : Self-checking bench for l2_cacheline_adaptor. A small memory
//               model answers the bursts. The expected behaviour is described
//               in terms of whole transactions: the line address is the
//               request address with its low five bits cleared. Read lines
//               are the memory beats concatenated in arrival order. Write
//               beats come from the line, starting with the low 64 bits.
//               The bench knows cycle by cycle whether the adaptor should be
//               bursting or completing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_i, write_i, resp_i;
  logic [AW-1:0] address_i;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic          resp_o, read_o, write_o;
  logic [AW-1:0] address_o;
  logic [BW-1:0] burst_o, burst_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Wait-state sequence for the gapped read: 1,0,0,1,1,0,1 (bit k = cycle k).
  logic [6:0] gap_pat = 7'b1011001;

  l2_cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One L2 transaction, from the request cycle in IDLE up to the idle cycle
  // after resp_o. mode selects the memory response pattern:
  // 0 = no waits, 1 = gap pattern, 2 = random waits, 3 = one-cycle first-beat latency.
  task automatic do_txn(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wline, input logic [LW-1:0] mline,
                        input int mode, input string tag);
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_ctl;
    logic [BW-1:0] exp_beat;
    bit            is_wr;
    bit            resp;
    int            beat;
    int            cyc;
    is_wr    = wr;
    exp_addr = addr & 32'hFFFF_FFE0;
    beat     = 0;
    cyc      = 0;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    burst_i   = {$urandom, $urandom};
    @(posedge clk); #1;
    // The request is latched; later changes must have no effect.
    address_i = $urandom;
    line_i    = rand_line();
    while (beat < NB) begin
      exp_ctl = {1'b0, !is_wr, is_wr};
      n_checks++;
      if ({resp_o, read_o, write_o} !== exp_ctl)
        $display("FAIL %s burst_ctl beat%0d cyc%0d: got resp/rd/wr=%b expected %b", tag, beat, cyc, {resp_o, read_o, write_o}, exp_ctl);
      else n_pass++;
      n_checks++;
      if (address_o !== exp_addr)
        $display("FAIL %s address_o: got %h expected %h", tag, address_o, exp_addr);
      else n_pass++;
      if (is_wr) begin
        exp_beat = wline[beat*BW +: BW];
        n_checks++;
        if (burst_o !== exp_beat)
          $display("FAIL %s burst_o beat%0d: got %h expected %h", tag, beat, burst_o, exp_beat);
        else n_pass++;
      end
      case (mode)
        1:       resp = gap_pat[cyc % 7];
        2:       resp = (cyc >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
        3:       resp = (cyc != 0);
        default: resp = 1'b1;
      endcase
      resp_i  = resp;
      burst_i = resp ? mline[beat*BW +: BW] : {$urandom, $urandom};
      if (resp) beat++;
      cyc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b100)
      $display("FAIL %s done_ctl: got resp/rd/wr=%b expected 100", tag, {resp_o, read_o, write_o});
    else n_pass++;
    if (!is_wr) begin
      n_checks++;
      if (line_o !== mline)
        $display("FAIL %s line_o: got %h expected %h", tag, line_o, mline);
      else n_pass++;
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'($urandom_range(0, 1));     // must be ignored in DONE
    burst_i = {$urandom, $urandom};
    @(posedge clk); #1;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000)
      $display("FAIL %s idle_ctl: got resp/rd/wr=%b expected 000", tag, {resp_o, read_o, write_o});
    else n_pass++;
    resp_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    @(posedge clk); #1;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== '0 || burst_o !== '0 || line_o !== '0)
      $display("FAIL reset_state: got ctl=%b addr=%h burst=%h line=%h expected all zero", {resp_o, read_o, write_o}, address_o, burst_o, line_o);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000)
      $display("FAIL reset_idle: got ctl=%b expected 000", {resp_o, read_o, write_o});
    else n_pass++;
  endtask

  task automatic test_read_basic();
    logic [LW-1:0] m;
    m = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(1'b0, 1'b1, 32'h0000_1234, rand_line(), m, 3, "read_basic");
  endtask

  task automatic test_write_basic();
    logic [LW-1:0] w;
    w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_txn(1'b1, 1'b0, 32'h8000_0040, w, rand_line(), 0, "write_basic");
  endtask

  task automatic test_read_gaps();
    do_txn(1'b0, 1'b1, $urandom, rand_line(), rand_line(), 1, "read_gaps");
  endtask

  task automatic test_priority();
    do_txn(1'b1, 1'b1, $urandom, rand_line(), rand_line(), 0, "priority");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    a = $urandom;
    do_txn(1'b1, 1'b0, a ^ 32'h0001_0000, rand_line(), rand_line(), 2, "writeback");
    do_txn(1'b0, 1'b1, a, rand_line(), rand_line(), 2, "refill");
  endtask

  task automatic test_reset_midburst();
    read_i = 1'b1; write_i = 1'b0;
    address_i = 32'h1234_5678; line_i = rand_line();
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'hDEAD_0000_0000_0000;
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'hDEAD_0000_0000_0001;
    @(posedge clk); #1;
    resp_i = 1'b0;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b010)
      $display("FAIL midburst_pre: got ctl=%b expected 010", {resp_o, read_o, write_o});
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== '0 || line_o !== '0)
      $display("FAIL midburst_abort: got ctl=%b addr=%h line=%h expected zeros", {resp_o, read_o, write_o}, address_o, line_o);
    else n_pass++;
    read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000)
      $display("FAIL midburst_idle: got ctl=%b expected 000", {resp_o, read_o, write_o});
    else n_pass++;
    do_txn(1'b0, 1'b1, $urandom, rand_line(), rand_line(), 0, "after_reset");
  endtask

  task automatic test_random();
    bit wr, rd;
    for (int t = 0; t < 20; t++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(wr, rd, $urandom, rand_line(), rand_line(), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_read_gaps();
    test_priority();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
